// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch stage: owns the PC, fetches one word per REQ/HOLD
// round trip and computes the redirected next PC when the datapath retires.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        advance,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] instr_count,
    output logic        misalign_err
);

    localparam logic [0:0] ST_REQ  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc_next;
    logic [31:0] br_off;

    assign imem_req  = (state == ST_REQ) && !reset;
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];

    // Redirect priority: jr over jump over taken branch over fall-through.
    always_comb begin
        br_off = {{14{imm16[15]}}, imm16, 2'b00};
        if (jr)
            pc_next = {jr_target[31:2], 2'b00};
        else if (jump)
            pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (branch_taken)
            pc_next = pc_plus4 + br_off;
        else
            pc_next = pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_REQ;
            pc           <= RESET_PC;
            instr        <= 32'h0;
            instr_valid  <= 1'b0;
            instr_count  <= 32'h0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                default: begin
                    if (advance) begin
                        pc          <= pc_next;
                        instr_valid <= 1'b0;
                        instr_count <= instr_count + 32'd1;
                        state       <= ST_REQ;
                        // Sticky: only a reset clears a misaligned-jr report.
                        if (jr && (jr_target[1:0] != 2'b00))
                            misalign_err <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the driver queues the expected next
// request (address, retire count, error flag) and fetched words; a monitor checks them.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance;
    logic        branch_taken;
    logic        jump;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] instr_count;
    logic        misalign_err;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .advance(advance), .branch_taken(branch_taken), .jump(jump),
        .jr(jr), .jr_target(jr_target),
        .instr_count(instr_count), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] cnt;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] instr_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] c, input logic m);
        exp_t e;
        e.addr = a;
        e.cnt  = c;
        e.mis  = m;
        exp_q.push_back(e);
    endtask

    // One full fetch/retire: optional wait states, then retire with redirects.
    task automatic do_instr(input logic [31:0] word, input int waits,
                            input logic br, input logic j, input logic r,
                            input logic [31:0] tgt, input logic [31:0] nxt,
                            input logic [31:0] cnt, input logic mis);
        int guard = 0;
        while (!imem_req && guard < 20) begin
            cycle();
            guard++;
        end
        if (!imem_req) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got imem_req=0 expected 1");
        end
        repeat (waits) cycle();
        imem_ready = 1'b1;
        imem_rdata = word;
        instr_q.push_back(word);
        cycle();
        imem_ready   = 1'b0;
        imem_rdata   = 32'hBAD0_BAD0;
        branch_taken = br;
        jump         = j;
        jr           = r;
        jr_target    = tgt;
        advance      = 1'b1;
        push_exp(nxt, cnt, mis);
        cycle();
        advance      = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        jr           = 1'b0;
        jr_target    = 32'h0;
    endtask

    // Monitor: sampled on the falling edge, away from input changes.
    logic        busy = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] held_addr = 32'h0;

    always @(negedge clk) begin
        if (reset) begin
            chk("req_in_reset", {31'b0, imem_req}, 32'd0);
            busy = 1'b0;
        end else begin
            if (imem_req) begin
                if (!busy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got addr %h expected none", imem_addr);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("req_addr", imem_addr, e.addr);
                        chk("pc_plus4", pc_plus4, e.addr + 32'd4);
                        chk("instr_count", instr_count, e.cnt);
                        chk("misalign_err", {31'b0, misalign_err}, {31'b0, e.mis});
                    end
                    held_addr = imem_addr;
                    busy = 1'b1;
                end else begin
                    chk("addr_stable", imem_addr, held_addr);
                end
                chk("valid_in_req", {31'b0, instr_valid}, 32'd0);
                if (imem_ready) busy = 1'b0;
            end
            if (instr_valid && !prev_valid) begin
                if (instr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got instr %h expected none", instr);
                end else begin
                    logic [31:0] w;
                    w = instr_q.pop_front();
                    chk("instr", instr, w);
                    chk("opcode", {26'b0, opcode}, {26'b0, w[31:26]});
                    chk("rs", {27'b0, rs}, {27'b0, w[25:21]});
                    chk("rt", {27'b0, rt}, {27'b0, w[20:16]});
                    chk("rd", {27'b0, rd}, {27'b0, w[15:11]});
                    chk("funct", {26'b0, funct}, {26'b0, w[5:0]});
                    chk("imm16", {16'b0, imm16}, {16'b0, w[15:0]});
                end
            end
        end
        prev_valid = instr_valid;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        imem_ready   = 1'b0;
        imem_rdata   = 32'h0;
        advance      = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        jr           = 1'b0;
        jr_target    = 32'h0;
        repeat (3) cycle();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_count", instr_count, 32'h0);
        chk("rst_mis", {31'b0, misalign_err}, 32'd0);
        push_exp(32'h0, 32'd0, 1'b0);
        reset = 1'b0;

        // Sequential zero-wait fetches: 0, 4, 8, 12
        do_instr(32'h0000_0020, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4,  32'd1, 1'b0);
        do_instr(32'h0123_4825, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8,  32'd2, 1'b0);
        do_instr(32'h8C43_0010, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hC,  32'd3, 1'b0);
        // Three wait states
        do_instr(32'hAC65_FFF0, 3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h10, 32'd4, 1'b0);
        // Branches from 0x100, backward then forward
        do_instr(32'h0000_0008, 0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h100, 32'd5, 1'b0);
        do_instr(32'h1000_FFFE, 0, 1'b1, 1'b0, 1'b0, 32'h0,   32'hFC,  32'd6, 1'b0);
        do_instr(32'h0000_0008, 0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h100, 32'd7, 1'b0);
        do_instr(32'h1000_0003, 0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h110, 32'd8, 1'b0);
        // Jump region and misaligned jr
        do_instr(32'h0000_0008, 0, 1'b0, 1'b0, 1'b1, 32'h1000_0000, 32'h1000_0000, 32'd9, 1'b0);
        do_instr(32'h0800_0040, 0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1000_0100, 32'd10, 1'b0);
        do_instr(32'h0000_0008, 0, 1'b0, 1'b0, 1'b1, 32'h0000_2002, 32'h2000, 32'd11, 1'b1);
        // All redirects at once: jr wins
        do_instr(32'h0800_0001, 0, 1'b1, 1'b1, 1'b1, 32'h3000, 32'h3000, 32'd12, 1'b1);
        // Fall-through wrap at top of memory
        do_instr(32'h0000_0008, 0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd13, 1'b1);
        do_instr(32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'd14, 1'b1);
        do_instr(32'h0000_0008, 0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h40, 32'd15, 1'b1);

        // Reset lands on the same edge as ready at pc 0x40
        @(negedge clk);
        #1;
        reset      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("req_during_reset", {31'b0, imem_req}, 32'd0);
        cycle();
        imem_ready = 1'b0;
        chk("abort_instr", instr, 32'h0);
        chk("abort_valid", {31'b0, instr_valid}, 32'd0);
        push_exp(32'h0, 32'd0, 1'b0);
        cycle();
        reset = 1'b0;
        do_instr(32'h2408_0005, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 32'd1, 1'b0);

        repeat (3) cycle();
        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("instr_q_drained", instr_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
